// File: rtl/stream_nucleotide_packer_if.sv
// stream_nucleotide_packer_if: ASCII beat input and packed read output stream bundle
interface stream_nucleotide_packer_if #(
  parameter int LENGTH = 64,
  parameter int BEAT = 8
);
  logic in_valid;
  logic in_ready;
  logic [BEAT*8-1:0] in_data;
  logic in_last;
  logic [$clog2(BEAT+1)-1:0] in_bytes;
  logic out_valid;
  logic out_ready;
  logic [2*LENGTH-1:0] out_read;
  logic [LENGTH-1:0] out_nmask;
  logic [$clog2(LENGTH+1)-1:0] out_len;
  logic out_truncated;
  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input in_ready, out_valid, out_read, out_nmask, out_len, out_truncated
  );
  modport slave (
    input in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_read, out_nmask, out_len, out_truncated
  );
endinterface

// File: rtl/stream_nucleotide_packer.sv
// stream_nucleotide_packer: packs ASCII DNA beats into 2-bit codes with N-mask, length and truncation flag
module stream_nucleotide_packer #(
  parameter int LENGTH = 64,
  parameter int BEAT = 8
) (
  input logic clk,
  input logic resetn,
  stream_nucleotide_packer_if.slave io
);
  localparam int CW = $clog2(LENGTH + 1);
  typedef enum logic [1:0] {FILL, DISCARD, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, eff;
  logic [2*LENGTH-1:0] read_q, read_d;
  logic [LENGTH-1:0] nmask_q, nmask_d;
  logic trunc_q, trunc_d, acc;
  function automatic logic [2:0] enc(input logic [7:0] c);
    return (c == 8'h41 || c == 8'h61) ? 3'b000 :
           (c == 8'h43 || c == 8'h63) ? 3'b001 :
           (c == 8'h47 || c == 8'h67) ? 3'b010 :
           (c == 8'h54 || c == 8'h74) ? 3'b011 : 3'b100;
  endfunction
  assign acc = io.in_valid && state_q != HOLD;
  assign eff = (io.in_last && io.in_bytes != '0) ? CW'(io.in_bytes) : CW'(BEAT);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    read_d = read_q;
    nmask_d = nmask_q;
    trunc_d = trunc_q;
    if (acc && state_q == FILL) begin
      // count is always beat-aligned in FILL, so slot k takes byte k%BEAT when its beat base equals count
      for (int k = 0; k < LENGTH; k++)
        if (CW'(k - k % BEAT) == count_q && CW'(k % BEAT) < eff)
          {nmask_d[k], read_d[2*k +: 2]} = enc(io.in_data[8*(k % BEAT) +: 8]);
      count_d = count_q + eff;
      state_d = io.in_last ? HOLD : (count_q + eff == CW'(LENGTH)) ? DISCARD : FILL;
    end
    if (acc && state_q == DISCARD) begin
      trunc_d = 1'b1;
      state_d = io.in_last ? HOLD : DISCARD;
    end
    if (state_q == HOLD && io.out_ready) begin
      state_d = FILL;
      count_d = '0;
      read_d = '0;
      nmask_d = '0;
      trunc_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= FILL;
      count_q <= '0;
      read_q <= '0;
      nmask_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      read_q <= read_d;
      nmask_q <= nmask_d;
      trunc_q <= trunc_d;
    end
  assign io.in_ready = state_q != HOLD;
  assign io.out_valid = state_q == HOLD;
  assign io.out_read = read_q;
  assign io.out_nmask = nmask_q;
  assign io.out_len = count_q;
  assign io.out_truncated = trunc_q;
endmodule

// File: tb/tb_stream_nucleotide_packer.sv
// tb_stream_nucleotide_packer: directed vectors for the nucleotide packer at LENGTH=8, BEAT=4
module tb_stream_nucleotide_packer;
  logic clk, resetn;
  int vectors = 0, errs = 0;
  stream_nucleotide_packer_if #(.LENGTH(8), .BEAT(4)) io ();
  stream_nucleotide_packer #(.LENGTH(8), .BEAT(4)) dut (.clk(clk), .resetn(resetn), .io(io));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] str4(input logic [31:0] s);
    return {s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send(input string tag, input logic [31:0] d, input logic l, input logic [2:0] b);
    int n = 0;
    io.in_valid = 1'b1;
    io.in_data = d;
    io.in_last = l;
    io.in_bytes = b;
    while (!io.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, "_ready_timeout"}, 0, 1);
    @(negedge clk);
    io.in_valid = 1'b0;
    io.in_data = 32'hDEADBEEF;
    io.in_last = 1'b1;
    io.in_bytes = 3'd3;
  endtask
  task automatic expect_read(input string tag, input logic [15:0] r, input logic [7:0] m,
                             input logic [3:0] l, input logic t);
    int n = 0;
    while (!io.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, io.out_valid, 1);
    check({tag, "_read"}, io.out_read, r);
    check({tag, "_nmask"}, io.out_nmask, m);
    check({tag, "_len"}, io.out_len, l);
    check({tag, "_trunc"}, io.out_truncated, t);
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    check({tag, "_taken"}, io.out_valid, 0);
    check({tag, "_ready_after"}, io.in_ready, 1);
  endtask
  initial begin
    resetn = 1'b0;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.in_last = 1'b0;
    io.in_bytes = '0;
    io.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", io.out_valid, 0);
    check("rst_read", io.out_read, 0);
    check("rst_nmask", io.out_nmask, 0);
    check("rst_len", io.out_len, 0);
    check("rst_trunc", io.out_truncated, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", io.in_ready, 1);
    send("t1a", str4("ACGT"), 1'b0, 3'd0);
    check("t1_mid_valid", io.out_valid, 0);
    send("t1b", str4("TGCA"), 1'b1, 3'd0);
    check("t1_latency", io.out_valid, 1);
    expect_read("t1", 16'h1BE4, 8'h00, 4'd8, 1'b0);
    send("t2", str4("acGN"), 1'b1, 3'd4);
    expect_read("t2", 16'h0024, 8'h08, 4'd4, 1'b0);
    send("t3", str4("CCxx"), 1'b1, 3'd2);
    expect_read("t3", 16'h0005, 8'h00, 4'd2, 1'b0);
    send("t4a", str4("AAAA"), 1'b0, 3'd0);
    send("t4b", str4("CCCC"), 1'b0, 3'd0);
    check("t4_discard_ready", io.in_ready, 1);
    check("t4_discard_valid", io.out_valid, 0);
    send("t4c", str4("GGGG"), 1'b1, 3'd0);
    expect_read("t4", 16'h5500, 8'h00, 4'd8, 1'b1);
    send("t5a", str4("TTTT"), 1'b1, 3'd0);
    io.in_valid = 1'b1;
    io.in_data = str4("GGGG");
    io.in_last = 1'b1;
    io.in_bytes = 3'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_ready", io.in_ready, 0);
      check("t5_hold_valid", io.out_valid, 1);
      check("t5_hold_read", io.out_read, 16'h00FF);
      check("t5_hold_len", io.out_len, 4);
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    check("t5_taken", io.out_valid, 0);
    check("t5_bubble_ready", io.in_ready, 1);
    @(negedge clk);
    io.in_valid = 1'b0;
    expect_read("t5b", 16'h00AA, 8'h00, 4'd4, 1'b0);
    send("t6a", str4("TTTT"), 1'b0, 3'd0);
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_len", io.out_len, 0);
    check("t6_rst_read", io.out_read, 0);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_no_valid", io.out_valid, 0);
    end
    send("t6b", str4("ACGT"), 1'b0, 3'd0);
    send("t6c", str4("TGCA"), 1'b1, 3'd0);
    expect_read("t6", 16'h1BE4, 8'h00, 4'd8, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
